// File: rtl/rst_seq_pkg.sv
// Shared types and width helpers for the reset sequencer.
// State encoding plus counter sizing used by the top and its timers.
package rst_seq_pkg;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    ASSERT   = 3'd1,
    HOLD     = 3'd2,
    RELEASE  = 3'd3,
    WAIT_REL = 3'd4
  } state_t;

  function automatic int clog2(input int n);
    int r;
    r = 0;
    while ((1 << r) < n) r++;
    return r;
  endfunction

  // Never let a counter collapse to zero bits.
  function automatic int cnt_w(input int n);
    return (clog2(n) < 1) ? 1 : clog2(n);
  endfunction

  localparam int DEF_NUM_OUTS = 3;
  localparam int DEF_HOLD_W   = cnt_w(16);
  localparam int DEF_ACK_W    = cnt_w(256);
  localparam int DEF_IDX_W    = cnt_w(DEF_NUM_OUTS);

endpackage

// File: rtl/rst_seq_timer.sv
// Saturating up-counter, reloaded to zero by load,
// with a flag for reaching the terminal value.
module rst_seq_timer #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [W-1:0] term,
  output logic         hit
);

  logic [W-1:0] count;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
    end else if (load) begin
      count <= '0;
    end else if (count != '1) begin
      count <= count + W'(1);
    end
  end

  assign hit = (count == term);

endmodule

// File: rtl/rst_seq_ctrl.sv
// Reset sequencer: asserts all domain resets, holds, then
// releases them in order and waits for acknowledgement.
module rst_seq_ctrl
  import rst_seq_pkg::*;
#(
  parameter int NUM_OUTS       = 3,
  parameter int HOLD_CYCLES    = 16,
  parameter int STAGGER_CYCLES = 4,
  parameter int ACK_TIMEOUT    = 255
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                sw_rst_req,
  input  logic                err_clr,
  input  logic [NUM_OUTS-1:0] rst_ack_in,
  output logic [NUM_OUTS-1:0] rst_out,
  output logic                busy,
  output logic                done,
  output logic                timeout_err
);

  localparam int HMAX = (HOLD_CYCLES > STAGGER_CYCLES) ?
                        HOLD_CYCLES : STAGGER_CYCLES;
  localparam int HW = cnt_w(HMAX);
  localparam int AW = cnt_w(ACK_TIMEOUT + 1);
  localparam int IW = cnt_w(NUM_OUTS);

  localparam logic [HW-1:0] H_TERM = HW'(HOLD_CYCLES - 1);
  localparam logic [HW-1:0] S_TERM = HW'(STAGGER_CYCLES - 1);
  localparam logic [AW-1:0] A_TERM =
    AW'((ACK_TIMEOUT > 0) ? ACK_TIMEOUT - 1 : 0);
  localparam logic [IW-1:0] LAST = IW'(NUM_OUTS - 1);
  localparam bit SKIP = (ACK_TIMEOUT == 0);

  state_t        state;
  logic [IW-1:0] idx;
  logic [HW-1:0] h_term;
  logic          h_hit;
  logic          a_hit;
  logic          tmo;
  logic          all0;
  logic          all1;
  logic          chg;
  logic          stag;

  assign all0   = ~|rst_ack_in;
  assign all1   = &rst_ack_in;
  assign tmo    = !SKIP && a_hit;
  assign h_term = (state == HOLD) ? H_TERM : S_TERM;

  // Timers restart on every state change; the hold timer
  // also restarts at each stagger step.
  always_comb begin
    chg  = 1'b0;
    stag = 1'b0;
    unique case (state)
      IDLE:     chg = sw_rst_req;
      ASSERT:   chg = all0 || SKIP || tmo;
      HOLD:     chg = h_hit;
      RELEASE: begin
        stag = h_hit;
        chg  = sw_rst_req || (h_hit && idx == LAST);
      end
      WAIT_REL: chg = sw_rst_req || all1 || SKIP || tmo;
      default:  chg = 1'b1;
    endcase
  end

  rst_seq_timer #(.W(HW)) u_hold (
    .clk  (clk),
    .rst  (rst),
    .load (chg || stag),
    .term (h_term),
    .hit  (h_hit)
  );

  rst_seq_timer #(.W(AW)) u_ack (
    .clk  (clk),
    .rst  (rst),
    .load (chg),
    .term (A_TERM),
    .hit  (a_hit)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= HOLD;
      rst_out     <= '0;
      busy        <= 1'b1;
      done        <= 1'b0;
      timeout_err <= 1'b0;
      idx         <= '0;
    end else begin
      done <= 1'b0;
      if (err_clr) timeout_err <= 1'b0;
      unique case (state)
        IDLE: begin
          if (sw_rst_req) begin
            state   <= ASSERT;
            rst_out <= '0;
            busy    <= 1'b1;
          end
        end
        ASSERT: begin
          if (all0 || SKIP) begin
            state <= HOLD;
          end else if (tmo) begin
            state       <= HOLD;
            timeout_err <= 1'b1;
          end
        end
        HOLD: begin
          if (h_hit) begin
            rst_out[0] <= 1'b1;
            idx        <= IW'(1);
            state      <= (NUM_OUTS == 1) ? WAIT_REL : RELEASE;
          end
        end
        RELEASE: begin
          if (sw_rst_req) begin
            state   <= ASSERT;
            rst_out <= '0;
          end else if (h_hit) begin
            rst_out[idx] <= 1'b1;
            idx          <= idx + IW'(1);
            if (idx == LAST) state <= WAIT_REL;
          end
        end
        WAIT_REL: begin
          if (sw_rst_req) begin
            state   <= ASSERT;
            rst_out <= '0;
          end else if (all1 || SKIP) begin
            state <= IDLE;
            busy  <= 1'b0;
            done  <= 1'b1;
          end else if (tmo) begin
            state       <= IDLE;
            busy        <= 1'b0;
            done        <= 1'b1;
            timeout_err <= 1'b1;
          end
        end
        default: begin
          state   <= HOLD;
          rst_out <= '0;
          busy    <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_rst_seq_ctrl.sv
// Scoreboard bench for rst_seq_ctrl: a phase/elapsed-time
// reference model queues per-cycle expectations for a monitor.
module tb_rst_seq_ctrl;

  localparam int N = 3;
  localparam int H = 16;
  localparam int S = 4;
  localparam int T = 255;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         sw  = 1'b0;
  logic         clr = 1'b0;
  logic [N-1:0] ack = '0;
  logic [N-1:0] rst_out;
  logic         busy;
  logic         done;
  logic         err;

  rst_seq_ctrl #(
    .NUM_OUTS       (N),
    .HOLD_CYCLES    (H),
    .STAGGER_CYCLES (S),
    .ACK_TIMEOUT    (T)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .sw_rst_req  (sw),
    .err_clr     (clr),
    .rst_ack_in  (ack),
    .rst_out     (rst_out),
    .busy        (busy),
    .done        (done),
    .timeout_err (err)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [N-1:0] ro;
    logic         bz;
    logic         dn;
    logic         er;
  } exp_t;

  typedef enum {M_IDLE, M_LOW, M_HOLD, M_STAG, M_HIGH} ph_t;

  exp_t         q[$];
  int           vectors = 0;
  int           miscompares = 0;
  int           cyc = 0;
  ph_t          ph;
  int           t;
  logic         m_err;
  logic         m_done;
  logic [N-1:0] cur;
  logic [N-1:0] prev;
  logic [N-1:0] stuck0 = '0;
  logic [N-1:0] stuck1 = '0;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] want);
    vectors++;
    if (act !== want) begin
      miscompares++;
      $display("FAIL %s cycle %0d: got %0h, want %0h",
               nm, cyc, act, want);
    end
  endtask

  // Outputs as a function of phase and time spent in it.
  function automatic logic [N-1:0] m_out();
    logic [N-1:0] r;
    r = '0;
    case (ph)
      M_IDLE, M_HIGH: r = {N{1'b1}};
      M_STAG: for (int i = 0; i < N; i++) r[i] = (t >= i * S);
      default: r = '0;
    endcase
    return r;
  endfunction

  task automatic model_reset();
    ph = M_HOLD; t = 0; m_err = 1'b0; m_done = 1'b0;
    cur = '0; prev = '0;
  endtask

  task automatic model_step(input bit s, input bit c,
                            input logic [N-1:0] a);
    m_done = 1'b0;
    if (c) m_err = 1'b0;
    case (ph)
      M_IDLE: if (s) begin ph = M_LOW; t = 0; end
      M_LOW: begin
        if (a == '0) begin ph = M_HOLD; t = 0; end
        else if (t + 1 >= T) begin m_err = 1'b1; ph = M_HOLD; t = 0; end
        else t++;
      end
      M_HOLD: begin
        if (t + 1 == H) begin ph = (N == 1) ? M_HIGH : M_STAG; t = 0; end
        else t++;
      end
      M_STAG: begin
        if (s) begin ph = M_LOW; t = 0; end
        else begin
          t++;
          if (t == (N - 1) * S) begin ph = M_HIGH; t = 0; end
        end
      end
      M_HIGH: begin
        if (s) begin ph = M_LOW; t = 0; end
        else if (a == {N{1'b1}}) begin ph = M_IDLE; m_done = 1'b1; t = 0; end
        else if (t + 1 >= T) begin
          ph = M_IDLE; m_done = 1'b1; m_err = 1'b1; t = 0;
        end
        else t++;
      end
      default: ph = M_HOLD;
    endcase
    prev = cur;
    cur  = m_out();
  endtask

  task automatic push();
    exp_t e;
    e.ro = cur;
    e.bz = (ph != M_IDLE);
    e.dn = m_done;
    e.er = m_err;
    q.push_back(e);
  endtask

  // Ack follows the expected rst_out two edges late, with stuck bits.
  task automatic cycle(input bit r, input bit s, input bit c);
    @(negedge clk);
    rst = r; sw = s; clr = c;
    ack = (prev & ~stuck0) | stuck1;
    if (r) model_reset();
    else model_step(s, c, ack);
    push();
  endtask

  task automatic run_until(input ph_t p, input int tt, input int cap);
    int n;
    n = 0;
    while (!(ph == p && (tt < 0 || t == tt)) && n < cap) begin
      cycle(1'b0, 1'b0, 1'b0);
      n++;
    end
    if (!(ph == p && (tt < 0 || t == tt))) begin
      vectors++;
      miscompares++;
      $display("FAIL wait_phase cycle %0d: got phase %0d, want %0d",
               cyc, ph, p);
    end
  endtask

  task automatic async_hit();
    @(negedge clk);
    sw = 1'b0; clr = 1'b0;
    #2 rst = 1'b1;
    #1;
    chk("async_rst_out", 32'(rst_out), 32'(0));
    chk("async_busy", 32'(busy), 32'(1));
    chk("async_done", 32'(done), 32'(0));
    chk("async_err", 32'(err), 32'(0));
    model_reset();
    push();
  endtask

  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      cyc++;
      if (q.size() > 0) begin
        e = q.pop_front();
        chk("rst_out", 32'(rst_out), 32'(e.ro));
        chk("busy", 32'(busy), 32'(e.bz));
        chk("done", 32'(done), 32'(e.dn));
        chk("timeout_err", 32'(err), 32'(e.er));
      end
    end
  end

  initial begin
    model_reset();
    repeat (3) cycle(1'b1, 1'b0, 1'b0);
    run_until(M_IDLE, -1, 400);

    cycle(1'b0, 1'b1, 1'b0);
    run_until(M_IDLE, -1, 400);

    stuck0 = 3'b010;
    cycle(1'b0, 1'b1, 1'b0);
    run_until(M_IDLE, -1, 800);
    stuck0 = '0;
    cycle(1'b0, 1'b0, 1'b1);
    repeat (3) cycle(1'b0, 1'b0, 1'b0);

    stuck1 = 3'b111;
    cycle(1'b0, 1'b1, 1'b0);
    run_until(M_IDLE, -1, 800);
    stuck1 = '0;
    repeat (3) cycle(1'b0, 1'b0, 1'b0);

    cycle(1'b0, 1'b1, 1'b0);
    run_until(M_HOLD, 8, 100);
    async_hit();
    cycle(1'b1, 1'b0, 1'b0);
    run_until(M_IDLE, -1, 400);

    cycle(1'b0, 1'b1, 1'b0);
    run_until(M_STAG, 1, 100);
    cycle(1'b0, 1'b1, 1'b0);
    run_until(M_IDLE, -1, 800);

    for (int i = 0; i < 3000; i++) begin
      case ($urandom_range(0, 199))
        0: stuck0 = N'($urandom);
        1: stuck1 = N'($urandom);
        2, 3, 4, 5: begin stuck0 = '0; stuck1 = '0; end
        default: ;
      endcase
      if ($urandom_range(0, 499) == 0)
        cycle(1'b1, 1'b0, 1'b0);
      else
        cycle(1'b0, $urandom_range(0, 99) < 3,
              $urandom_range(0, 99) < 4);
    end

    stuck0 = '0;
    stuck1 = '0;
    run_until(M_IDLE, -1, 800);
    @(posedge clk);
    #2;
    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

endmodule
